// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer: synchronizes the raw line, samples mid-bit and
// pushes each good byte into the RX FIFO. It also flags framing and overrun errors.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    input  logic       rx_full,
    output logic       uart_write,
    output logic [7:0] uart_data,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          uart_write_q;
    logic [7:0]    uart_data_q;
    logic          frame_err_q;
    logic          overrun_err_q;
    logic          rx_busy_q;
    logic          rxd_s;

    assign rxd_s       = sync_q[1];
    assign uart_write  = uart_write_q;
    assign uart_data   = uart_data_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign rx_busy     = rx_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            uart_write_q  <= 1'b0;
            uart_data_q   <= '0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], uart_rxd};
            uart_write_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_q   <= START;
                        cnt_q     <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (rxd_s) begin
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            // Back to IDLE at mid-stop so an immediate next start bit is seen.
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                            if (rx_full) begin
                                overrun_err_q <= 1'b1;
                            end else begin
                                uart_data_q  <= shift_q;
                                uart_write_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= WAIT_HIGH;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit: good bytes, glitch,
// framing/break, overrun, back-to-back frames and reset mid-byte.
module tb_uart_rx_deser;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       uart_rxd;
    logic       rx_full;
    logic       uart_write;
    logic [7:0] uart_data;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .rx_full    (rx_full),
        .uart_write (uart_write),
        .uart_data  (uart_data),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int       wr_cnt = 0;
    int       fe_cnt = 0;
    int       ov_cnt = 0;
    int       busy_cycles = 0;
    int       last_wr_cyc = 0;
    int       busy_rise_cyc = 0;
    int       busy_fall_cyc = 0;
    logic [7:0] last_wr_data = 8'h00;
    logic     busy_prev = 1'b0;

    always @(negedge clk) begin
        if (uart_write) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_data = uart_data;
            last_wr_cyc  = cyc;
        end
        if (frame_err)   fe_cnt = fe_cnt + 1;
        if (overrun_err) ov_cnt = ov_cnt + 1;
        if (rx_busy)     busy_cycles = busy_cycles + 1;
        if (!busy_prev && rx_busy) busy_rise_cyc = cyc;
        if (busy_prev && !rx_busy) busy_fall_cyc = cyc;
        busy_prev = rx_busy;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    int start_cyc;

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        $display("tx frame 0x%02h stop=%0b start_cyc=%0d", d, stop, start_cyc);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int wr0, fe0, ov0, b0, w1;

    initial begin
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        rx_full  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_write", uart_write, 0);
        check("rst_data", uart_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun_err, 0);
        rst_n = 1'b1;
        idle(5);

        // Good byte with latency: T0 = start_cyc+2, strobe at T0+153.
        wr0 = wr_cnt;
        send_frame(8'hA5, 1'b1);
        check("good_count", wr_cnt - wr0, 1);
        check("good_data", last_wr_data, 8'hA5);
        check("good_latency", last_wr_cyc - start_cyc, 155);
        check("busy_rise", busy_rise_cyc - start_cyc, 3);
        check("busy_fall", busy_fall_cyc - start_cyc, 155);
        idle(10);

        // Glitch: 4 low cycles, then idle.
        wr0 = wr_cnt; fe0 = fe_cnt; ov0 = ov_cnt; b0 = busy_cycles;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("glitch_write", wr_cnt - wr0, 0);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check("glitch_ovr", ov_cnt - ov0, 0);
        check("glitch_busy_cycles", busy_cycles - b0, 8);
        check("glitch_idle", rx_busy, 0);
        send_frame(8'h3C, 1'b1);
        check("after_glitch_count", wr_cnt - wr0, 1);
        check("after_glitch_data", last_wr_data, 8'h3C);
        idle(10);

        // Framing error followed by a long break.
        wr0 = wr_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check("frame_err_count", fe_cnt - fe0, 1);
        check("frame_no_write", wr_cnt - wr0, 0);
        check("frame_data_kept", uart_data, 8'h3C);
        check("break_busy", rx_busy, 1);
        idle(20);
        check("break_released", rx_busy, 0);
        send_frame(8'h81, 1'b1);
        check("after_break_count", wr_cnt - wr0, 1);
        check("after_break_data", last_wr_data, 8'h81);
        idle(10);

        // Overrun.
        wr0 = wr_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
        rx_full = 1'b1;
        send_frame(8'hFF, 1'b1);
        check("ovr_count", ov_cnt - ov0, 1);
        check("ovr_no_write", wr_cnt - wr0, 0);
        check("ovr_no_ferr", fe_cnt - fe0, 0);
        check("ovr_data_kept", uart_data, 8'h81);
        rx_full = 1'b0;
        idle(10);
        send_frame(8'h12, 1'b1);
        check("after_ovr_count", wr_cnt - wr0, 1);
        check("after_ovr_data", last_wr_data, 8'h12);
        idle(10);

        // Back-to-back frames with no idle between stop and start.
        wr0 = wr_cnt;
        send_frame(8'h00, 1'b1);
        check("b2b_first_data", last_wr_data, 8'h00);
        w1 = last_wr_cyc;
        send_frame(8'hFF, 1'b1);
        check("b2b_count", wr_cnt - wr0, 2);
        check("b2b_second_data", last_wr_data, 8'hFF);
        check("b2b_spacing", last_wr_cyc - w1, 160);
        idle(10);

        // Reset in the middle of data bit 4 of 0xC3.
        wr0 = wr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
        uart_rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_data", uart_data, 0);
        check("mid_rst_write", uart_write, 0);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("mid_rst_no_write", wr_cnt - wr0, 0);
        send_frame(8'h7E, 1'b1);
        check("after_rst_count", wr_cnt - wr0, 1);
        check("after_rst_data", last_wr_data, 8'h7E);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
